mode_counter: RTL

MODE_COUNTER -- requirements
Module: mode_counter

---
 rtl/mode_counter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mode_counter.sv
// Multi-mode bounded counter: up-wrap, down-wrap, ping-pong and up-saturate.
// The count always stays inside [COUNT_MIN, COUNT_MAX].
// clear beats load, and load beats a clk_enable step.
// wrap_pulse is a registered flag that is high for one cycle after a wrap or turnaround.
module mode_counter #(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned COUNT_MIN = 0,
  parameter int unsigned COUNT_MAX = 63,
  parameter int unsigned STEP      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_enable,
  input  logic [1:0]       mode,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] current_count,
  output logic             direction,
  output logic             phase_min,
  output logic             phase_max,
  output logic             wrap_pulse,
  output logic             saturated
);

  typedef enum logic [1:0] {
    ModeUpWrap   = 2'b00,
    ModeDownWrap = 2'b01,
    ModePingPong = 2'b10,
    ModeUpSat    = 2'b11
  } mode_e;

  // Ping-pong landing points after a turnaround, kept inside the legal range.
  localparam int unsigned PpDownTo    = (COUNT_MAX >= COUNT_MIN + STEP) ? COUNT_MAX - STEP
                                                                        : COUNT_MIN;
  localparam int unsigned PpUpTo      = (COUNT_MIN + STEP <= COUNT_MAX) ? COUNT_MIN + STEP
                                                                        : COUNT_MAX;
  localparam int unsigned MinPlusStep = COUNT_MIN + STEP;

  // Widened (WIDTH+1) constants so that count+STEP is compared without overflow.
  localparam logic [WIDTH:0]   MaxX     = COUNT_MAX[WIDTH:0];
  localparam logic [WIDTH:0]   StepX    = STEP[WIDTH:0];
  localparam logic [WIDTH:0]   MinStepX = MinPlusStep[WIDTH:0];

  localparam logic [WIDTH-1:0] MinW     = COUNT_MIN[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MaxW     = COUNT_MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] StepW    = STEP[WIDTH-1:0];
  localparam logic [WIDTH-1:0] PpDownW  = PpDownTo[WIDTH-1:0];
  localparam logic [WIDTH-1:0] PpUpW    = PpUpTo[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH:0]   count_x;
  logic [WIDTH:0]   up_x;
  logic [WIDTH-1:0] dn_w;
  logic [WIDTH:0]   load_x;
  logic             up_over;
  logic             dn_under;
  logic             load_below_min;
  logic             load_above_max;
  logic             at_min;
  logic             at_max;
  mode_e            mode_sel;

  assign mode_sel       = mode_e'(mode);
  assign count_x        = {1'b0, count_q};
  assign up_x           = count_x + StepX;
  assign dn_w           = count_q - StepW;
  assign load_x         = {1'b0, load_value};
  assign up_over        = (up_x > MaxX);
  assign dn_under       = (count_x < MinStepX);
  assign load_above_max = (load_x > MaxX);
  assign at_min         = (count_q == MinW);
  assign at_max         = (count_q == MaxW);

  // A lower clamp only exists when COUNT_MIN is above zero.
  if (COUNT_MIN > 0) begin : g_low_clamp
    localparam logic [WIDTH:0] MinX = COUNT_MIN[WIDTH:0];
    assign load_below_min = (load_x < MinX);
  end else begin : g_no_low_clamp
    assign load_below_min = 1'b0;
  end

  // Next-state selection: clear, then load, then the mode-dependent step.
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = MinW;
      dir_d   = 1'b1;
    end else if (load) begin
      if (load_below_min) begin
        count_d = MinW;
      end else if (load_above_max) begin
        count_d = MaxW;
      end else begin
        count_d = load_value;
      end
    end else if (clk_enable) begin
      unique case (mode_sel)
        ModeUpWrap: begin
          dir_d = 1'b1;
          if (up_over) begin
            count_d = MinW;
            wrap_d  = 1'b1;
          end else begin
            count_d = up_x[WIDTH-1:0];
          end
        end
        ModeDownWrap: begin
          dir_d = 1'b0;
          if (dn_under) begin
            count_d = MaxW;
            wrap_d  = 1'b1;
          end else begin
            count_d = dn_w;
          end
        end
        ModePingPong: begin
          if (dir_q) begin
            if (at_max) begin
              dir_d   = 1'b0;
              count_d = PpDownW;
              wrap_d  = 1'b1;
            end else if (up_over) begin
              count_d = MaxW;
            end else begin
              count_d = up_x[WIDTH-1:0];
            end
          end else begin
            if (at_min) begin
              dir_d   = 1'b1;
              count_d = PpUpW;
              wrap_d  = 1'b1;
            end else if (dn_under) begin
              count_d = MinW;
            end else begin
              count_d = dn_w;
            end
          end
        end
        ModeUpSat: begin
          dir_d   = 1'b1;
          count_d = up_over ? MaxW : up_x[WIDTH-1:0];
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // State registers; reset returns to COUNT_MIN counting up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= MinW;
      dir_q   <= 1'b1;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
    end
  end

  // Output decode.
  always_comb begin
    current_count = count_q;
    direction     = dir_q;
    wrap_pulse    = wrap_q;
    phase_min     = at_min & clk_enable;
    phase_max     = at_max & clk_enable;
    saturated     = (mode_sel == ModeUpSat) & at_max;
  end

endmodule
